// File: rtl/settings_bus_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the settings-bus arbiter family.
package settings_bus_arbiter_pkg;

  localparam int SETTINGS_ADDR_W = 7;
  localparam int SETTINGS_DATA_W = 32;
  localparam int LOCK_TIMEOUT    = 64;
  localparam int LOCK_TMR_W      = $clog2(LOCK_TIMEOUT);
  localparam int IDX_W           = 3;
  localparam int GAP_W           = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STROBE = 2'd1,
    ARB_GAP    = 2'd2
  } arb_state_t;

  // Round-robin successor of idx over n requesters.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/settings_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first masked request at or above the pointer,
// wrapping modulo N. Produces a one-hot grant, its index and an any-valid flag.
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic [N-1:0]     i_mask,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_req;

  assign w_req = i_req & i_mask;

  // Scan by distance from the pointer; every index is a constant so no variable bit-select.
  always_comb begin
    int pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        pos = int'(i_ptr) + k;
        if (pos >= N) pos = pos - N;
        if (!o_any && w_req[i] && (pos == i)) begin
          o_any      = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing the settings write bus between NUM_REQ requesters.
// Optional atomic-sequence locking is compiled in with `define SETTINGS_ARB_LOCK_EN.
module settings_bus_arbiter
  import settings_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                               master_clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [SETTINGS_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [SETTINGS_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_lock,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [SETTINGS_ADDR_W-1:0]         serial_addr,
  output logic [SETTINGS_DATA_W-1:0]         serial_data,
  output logic                               serial_strobe,
  output logic                               busy,
  output logic [IDX_W-1:0]                   grant_id,
  output arb_state_t                         dbg_state
);

  // Handshake: requester i transfers on a cycle where req_valid[i] && req_ready[i];
  // ready is only offered in IDLE, to one requester, and never depends on a later cycle.

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("settings_bus_arbiter: NUM_REQ must be in 2..8");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("settings_bus_arbiter: GAP_CYCLES must be in 0..15");
  end

  arb_state_t                 r_state;
  arb_state_t                 w_next_state;
  logic [IDX_W-1:0]           r_ptr;
  logic [GAP_W-1:0]           r_gap_cnt;
  logic [SETTINGS_ADDR_W-1:0] r_addr;
  logic [SETTINGS_DATA_W-1:0] r_data;
  logic [IDX_W-1:0]           r_grant_id;

  logic [NUM_REQ-1:0]         w_mask;
  logic [NUM_REQ-1:0]         w_grant;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_any;
  logic                       w_accept;
  logic [SETTINGS_ADDR_W-1:0] w_sel_addr;
  logic [SETTINGS_DATA_W-1:0] w_sel_data;

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_mask  (w_mask),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == ARB_IDLE) && w_any && reset_n;

  // One-hot payload mux driven by the picker grant.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*SETTINGS_ADDR_W +: SETTINGS_ADDR_W];
        w_sel_data = req_data[i*SETTINGS_DATA_W +: SETTINGS_DATA_W];
      end
    end
  end

`ifdef SETTINGS_ARB_LOCK_EN
  logic                  r_lock_vld;
  logic [IDX_W-1:0]      r_lock_id;
  logic [LOCK_TMR_W-1:0] r_lock_tmr;
  logic [NUM_REQ-1:0]    w_lock_onehot;
  logic                  w_holder_valid;
  logic                  w_win_lock;

  always_comb begin
    w_lock_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_lock_onehot[i] = r_lock_vld && (r_lock_id == IDX_W'(i));
    end
  end

  assign w_mask         = r_lock_vld ? w_lock_onehot : '1;
  assign w_holder_valid = |(req_valid & w_lock_onehot);
  assign w_win_lock     = |(req_lock & w_grant);

  // While locked only the holder can win, so an unlocked accept is always the holder's release.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_lock_tmr <= '0;
    end else if (w_accept) begin
      r_lock_tmr <= '0;
      if (w_win_lock) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_idx;
      end else begin
        r_lock_vld <= 1'b0;
      end
    end else if ((r_state == ARB_IDLE) && r_lock_vld && !w_holder_valid) begin
      if (r_lock_tmr == LOCK_TMR_W'(LOCK_TIMEOUT - 1)) begin
        r_lock_vld <= 1'b0;
        r_lock_tmr <= '0;
      end else begin
        r_lock_tmr <= r_lock_tmr + 1'b1;
      end
    end else begin
      r_lock_tmr <= '0;
    end
  end
`else
  logic w_unused_lock;

  assign w_mask        = '1;
  assign w_unused_lock = ^req_lock;
`endif

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any) w_next_state = ARB_STROBE;
      ARB_STROBE: w_next_state = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
      ARB_GAP:    if (r_gap_cnt <= GAP_W'(1)) w_next_state = ARB_IDLE;
      default:    w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    serial_strobe = 1'b0;
    busy          = 1'b0;
    case (r_state)
      ARB_IDLE:   req_ready = reset_n ? w_grant : '0;
      ARB_STROBE: begin
        serial_strobe = 1'b1;
        busy          = 1'b1;
      end
      default:    busy = 1'b1;
    endcase
  end

  // Payload registers hold after the strobe; downstream samples only on serial_strobe.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
    end else if (w_accept) begin
      r_addr     <= w_sel_addr;
      r_data     <= w_sel_data;
      r_grant_id <= w_idx;
      r_ptr      <= rr_next(w_idx, NUM_REQ);
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_cnt <= '0;
    end else if (r_state == ARB_STROBE) begin
      r_gap_cnt <= GAP_W'(GAP_CYCLES);
    end else if ((r_state == ARB_GAP) && (r_gap_cnt != '0)) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  assign serial_addr = r_addr;
  assign serial_data = r_data;
  assign grant_id    = r_grant_id;
  assign dbg_state   = r_state;

endmodule
